auth_ctrl: RTL
==============

AUTH_CTRL -- requirements
Module: auth_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the command byte width.
REQ-002 The block SHALL have parameter GO_CODE, default 8'h67, the power-up command ('g').
REQ-003 The block SHALL have parameter STOP_CODE, default 8'h73, the power-down request ('s').
REQ-004 The block SHALL have parameter TMO_CYC, default 50_000_000, the link-loss timeout in clk cycles (must be >= 2).
REQ-005 The block SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have port rx_rdy, input, 1, meaning a UART byte is valid on rx_data.
REQ-008 The block SHALL have port rx_data, input, DATA_W, the received command byte.
REQ-009 The block SHALL have port rider_off, input, 1, meaning the rider weight is below threshold.
REQ-010 The block SHALL have port clr_rx_rdy, output, 1, the consume strobe back to the UART receiver.
REQ-011 The block SHALL have port pwr_up, output, 1, which enables the balance and motor path.
REQ-012 The block SHALL have port link_lost, output, 1, a sticky flag: power was dropped by timeout.

Function
REQ-013 The block SHALL implement FSM states OFF, PWR1 (powered) and PWR2 (stop pending, waiting for rider_off).
REQ-014 In OFF, the FSM SHALL go to PWR1 when rx_rdy && rx_data==GO_CODE; all other bytes are ignored.
REQ-015 In PWR1 with rx_rdy && rx_data==STOP_CODE, the FSM SHALL go to OFF if rider_off, else to PWR2.
REQ-016 In PWR1, rider_off alone SHALL NOT change state.
REQ-017 In PWR2, rx_rdy && rx_data==GO_CODE SHALL go to PWR1; otherwise rider_off SHALL go to OFF.
REQ-018 If GO and rider_off occur in the same cycle in PWR2, GO SHALL win (next state PWR1).
REQ-019 A repeated STOP in PWR2 or OFF, or a repeated GO in PWR1, SHALL cause no state change.
REQ-020 pwr_up SHALL be a registered output, high exactly when the state is PWR1 or PWR2, with one-cycle latency after the triggering rx_rdy edge.
REQ-021 clr_rx_rdy SHALL be combinational, equal to rx_rdy, so every byte (including unrecognised codes) is consumed in the cycle it is presented.
REQ-022 Comparison SHALL use the full DATA_W bits; any code other than GO_CODE/STOP_CODE (e.g. 8'h66) SHALL be a no-op.

Reset
REQ-023 On rst_n low at a clk edge, the block SHALL set state=OFF, pwr_up=0, link_lost=0, and watchdog count=0.
REQ-024 Reset asserted in PWR1/PWR2 SHALL drop pwr_up on the next edge regardless of rider_off.
REQ-025 clr_rx_rdy SHALL follow rx_rdy even during reset.

Configuration
REQ-026 With macro AUTH_LINK_TMO_EN defined, the watchdog SHALL count clk cycles while the state is PWR1; the count clears on any rx_rdy, and on leaving PWR1.
REQ-027 With AUTH_LINK_TMO_EN defined, reaching TMO_CYC-1 with no rx_rdy SHALL act as a STOP: go to OFF if rider_off, else to PWR2; link_lost is then set.
REQ-028 With AUTH_LINK_TMO_EN defined, rx_rdy in the terminal cycle SHALL take priority over timeout.
REQ-029 With AUTH_LINK_TMO_EN defined, link_lost SHALL clear on the next accepted GO.
REQ-030 Without AUTH_LINK_TMO_EN, no timer logic SHALL exist, link_lost SHALL be tied 0, and behaviour SHALL be REQ-013..022 only.

Structure
REQ-031 Package auth_pkg SHALL hold the state enum (OFF/PWR1/PWR2) and default GO/STOP code localparams.
REQ-032 The timer SHALL be sub-module auth_wdog with counter width $clog2(TMO_CYC), ports clk, rst_n, en, clr and expire, instantiated only under AUTH_LINK_TMO_EN.

Verification
REQ-033 The bench SHALL cover: reset, then GO 8'h67 -> pwr_up=1 within 1 cycle of rx_rdy; clr_rx_rdy pulses 1 cycle.
REQ-034 The bench SHALL cover: PWR1, rider_off=0, STOP 8'h73 -> pwr_up stays 1 (PWR2); then rider_off=1 -> pwr_up=0 next cycle.
REQ-035 The bench SHALL cover: OFF, send 8'h73 then 8'h66 -> pwr_up stays 0; then GO -> pwr_up=1.
REQ-036 The bench SHALL cover: PWR2, GO together with rider_off=1 in the same cycle -> state PWR1, pwr_up=1.
REQ-037 The bench SHALL cover (AUTH_LINK_TMO_EN, TMO_CYC=1000): GO, then 1000 idle cycles with rider_off=1 -> pwr_up=0 and link_lost=1; GO -> link_lost=0; a byte every 900 cycles -> no timeout.
REQ-038 The bench SHALL cover: rst_n low for 1 cycle while in PWR1 -> pwr_up=0 and state OFF next edge.

Source files
------------

// File: rtl/auth_pkg.sv
// rtl/auth_pkg.sv - shared FSM state encoding and default command codes for auth_ctrl.
package auth_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    PWR1 = 2'd1,
    PWR2 = 2'd2
  } auth_state_e;

  localparam logic [7:0] GO_CODE_DEF   = 8'h67;
  localparam logic [7:0] STOP_CODE_DEF = 8'h73;

endpackage

// File: rtl/auth_wdog.sv
// rtl/auth_wdog.sv - link-loss watchdog; expire is high in the cycle the count reaches TMO_CYC-1.
module auth_wdog #(
  parameter int TMO_CYC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CNT_W = $clog2(TMO_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // A clear in the terminal cycle suppresses the expiry.
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/auth_ctrl.sv
// rtl/auth_ctrl.sv - power-up authorisation FSM driven by UART command bytes and rider presence.
// Define AUTH_LINK_TMO_EN to add the link-loss watchdog and the sticky link_lost flag.
module auth_ctrl
  import auth_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] GO_CODE   = DATA_W'(GO_CODE_DEF),
  parameter logic [DATA_W-1:0] STOP_CODE = DATA_W'(STOP_CODE_DEF),
  parameter int                TMO_CYC   = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rider_off,
  output logic              clr_rx_rdy,
  output logic              pwr_up,
  output logic              link_lost
);

  if (TMO_CYC < 2) begin : g_bad_tmo
    $error("auth_ctrl: TMO_CYC must be at least 2");
  end

  auth_state_e state, state_nxt;
  logic        go_hit, stop_hit, tmo_hit;

  assign go_hit     = rx_rdy && (rx_data == GO_CODE);
  assign stop_hit   = rx_rdy && (rx_data == STOP_CODE);
  assign clr_rx_rdy = rx_rdy;

`ifdef AUTH_LINK_TMO_EN
  logic wdog_en, wdog_clr, link_lost_q;

  assign wdog_en  = (state == PWR1);
  assign wdog_clr = rx_rdy || (state != PWR1);

  auth_wdog #(
    .TMO_CYC(TMO_CYC)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wdog_en),
    .clr   (wdog_clr),
    .expire(tmo_hit)
  );

  // Set by a timeout drop, cleared only by a GO that actually powers up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_lost_q <= 1'b0;
    end else if (tmo_hit) begin
      link_lost_q <= 1'b1;
    end else if (go_hit && (state != PWR1)) begin
      link_lost_q <= 1'b0;
    end
  end

  assign link_lost = link_lost_q;
`else
  assign tmo_hit   = 1'b0;
  assign link_lost = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      OFF: begin
        if (go_hit) state_nxt = PWR1;
      end
      PWR1: begin
        // A timeout behaves exactly like a received STOP.
        if (stop_hit || tmo_hit) state_nxt = rider_off ? OFF : PWR2;
      end
      PWR2: begin
        if (go_hit)         state_nxt = PWR1;
        else if (rider_off) state_nxt = OFF;
      end
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= OFF;
      pwr_up <= 1'b0;
    end else begin
      state  <= state_nxt;
      pwr_up <= (state_nxt != OFF);
    end
  end

endmodule
